// File: rtl/pair_seq_pkg.sv
// Shared definitions for the pair sequencer: state encoding and default MemoryA address width.
package pair_seq_pkg;

  localparam int DEFAULT_A_AW = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FETCH0 = 3'd2,
    FETCH1 = 3'd3,
    DONE   = 3'd4
  } seqState_t;

endpackage

// File: rtl/seq_addr_counter.sv
// Address counter with synchronous active-low reset, synchronous clear and increment enable.
// Incrementing past the all-ones value wraps to zero.
module seq_addr_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pair_sequencer.sv
// Loads MemoryA sequentially, then walks it in (even, odd) pairs, writing one MemoryB word per pair.
// Optional feature macro: PAIR_SEQ_ABORT_EN adds an abort input that cancels a run in progress.
module pair_sequencer
  import pair_seq_pkg::*;
#(
  parameter  int A_AW = DEFAULT_A_AW,
  localparam int B_AW = A_AW - 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            dataValid,
`ifdef PAIR_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            wea,
  output logic [A_AW-1:0] addressA,
  output logic            ffEn,
  output logic            web,
  output logic [B_AW-1:0] addressB,
  output logic            busy,
  output logic            done
);

  localparam logic [A_AW-1:0] A_LAST = {A_AW{1'b1}};
  localparam logic [B_AW-1:0] B_LAST = {B_AW{1'b1}};

  seqState_t stateReg, stateNext;
  logic      incA, incB, clearAddr;
  logic      abortHit;

`ifdef PAIR_SEQ_ABORT_EN
  assign abortHit = abort && (stateReg == LOAD || stateReg == FETCH0 || stateReg == FETCH1);
`else
  assign abortHit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    wea       = 1'b0;
    ffEn      = 1'b0;
    web       = 1'b0;
    incA      = 1'b0;
    incB      = 1'b0;
    clearAddr = 1'b0;
    case (stateReg)
      IDLE: begin
        clearAddr = 1'b1;
        if (start) stateNext = LOAD;
      end
      LOAD: begin
        if (dataValid) begin
          wea  = 1'b1;
          incA = 1'b1;
          if (addressA == A_LAST) stateNext = FETCH0;
        end
      end
      FETCH0: begin
        ffEn      = 1'b1;
        incA      = 1'b1;
        stateNext = FETCH1;
      end
      FETCH1: begin
        web  = 1'b1;
        incA = 1'b1;
        incB = 1'b1;
        stateNext = (addressB == B_LAST) ? DONE : FETCH0;
      end
      DONE: begin
        clearAddr = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        clearAddr = 1'b1;
        stateNext = IDLE;
      end
    endcase
    if (abortHit) begin
      stateNext = IDLE;
      wea       = 1'b0;
      ffEn      = 1'b0;
      web       = 1'b0;
      incA      = 1'b0;
      incB      = 1'b0;
      clearAddr = 1'b1;
    end
    // Strobes are held low while reset is asserted, whatever state is still registered.
    if (!reset) begin
      wea  = 1'b0;
      ffEn = 1'b0;
      web  = 1'b0;
    end
  end

  assign busy = reset && (stateReg != IDLE);
  assign done = reset && (stateReg == DONE);

  seq_addr_counter #(.W(A_AW)) addrACounter (
    .clock (clock),
    .reset (reset),
    .clear (clearAddr),
    .inc   (incA),
    .count (addressA)
  );

  seq_addr_counter #(.W(B_AW)) addrBCounter (
    .clock (clock),
    .reset (reset),
    .clear (clearAddr),
    .inc   (incB),
    .count (addressB)
  );

endmodule

// File: tb/tb_pair_sequencer.sv
// Randomized bench for pair_sequencer: per-cycle expected outputs come from a run plan built from the load pattern.
// With PAIR_SEQ_ABORT_EN defined the abort path is exercised as well.
module tb_pair_sequencer;

  localparam int A_AW  = 3;
  localparam int B_AW  = 2;
  localparam int DEPTH = 8;
  localparam int PAIRS = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            dataValid = 1'b0;
  logic            wea, ffEn, web, busy, done;
  logic [A_AW-1:0] addressA;
  logic [B_AW-1:0] addressB;
`ifdef PAIR_SEQ_ABORT_EN
  logic            abort = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] dataIn = 8'h00;
  logic [7:0] memA [DEPTH];
  logic [7:0] memB [PAIRS];
  logic [7:0] ffReg;

  always #5 clock = ~clock;

  pair_sequencer #(.A_AW(A_AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dataValid (dataValid),
`ifdef PAIR_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .wea       (wea),
    .addressA  (addressA),
    .ffEn      (ffEn),
    .web       (web),
    .addressB  (addressB),
    .busy      (busy),
    .done      (done)
  );

  // External datapath: MemoryA, the capture flop and MemoryB, with f(x, y) = x + y.
  always @(posedge clock) begin
    if (wea)  memA[addressA] <= dataIn;
    if (ffEn) ffReg <= memA[addressA];
    if (web)  memB[addressB] <= ffReg + memA[addressA];
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pack(input logic we, input logic [2:0] aA, input logic ff,
                                      input logic wb, input logic [1:0] aB, input logic bs,
                                      input logic dn);
    return {we, aA, ff, wb, aB, bs, dn};
  endfunction

  function automatic logic [9:0] observed();
    return {wea, addressA, ffEn, web, addressB, busy, done};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Apply inputs for one cycle just after the edge, then compare outputs mid-cycle.
  task automatic stepCycle(input logic s, input logic dv, input logic [7:0] d,
                           input logic [9:0] exp, input string tag);
    @(posedge clock);
    #1;
    start = s;
    dataValid = dv;
    dataIn = d;
    #1;
    checkValue(tag, {22'd0, observed()}, {22'd0, exp});
  endtask

  // mode 0: continuous dataValid, 1: toggling 0,1,..., 2: random. expDone=0 skips the latency check.
  task automatic runOnce(input int mode, input int expDone, input string name);
    logic [7:0] loaded [DEPTH];
    logic       dv;
    logic [7:0] d;
    int         w;
    int         rel;
    stepCycle(1'b1, rbit(), 8'($urandom), pack(0, 0, 0, 0, 0, 0, 0), {name, "_idleStart"});
    w = 0;
    rel = 1;
    while (w < DEPTH && rel < 300) begin
      dv = (mode == 0) ? 1'b1 : (mode == 1) ? ((rel % 2) == 0) : rbit();
      d  = 8'($urandom);
      stepCycle(rbit(), dv, d, pack(dv, 3'(w), 0, 0, 0, 1, 0), {name, "_load"});
      if (dv) begin
        loaded[w] = d;
        w++;
      end
      rel++;
    end
    if (w < DEPTH) checkValue({name, "_loadBound"}, 32'(w), 32'(DEPTH));
    for (int j = 0; j < DEPTH; j++) begin
      stepCycle((j == 0) ? 1'b1 : rbit(), rbit(), 8'($urandom),
                pack(0, 3'(j), (j % 2) == 0, (j % 2) == 1, 2'(j / 2), 1, 0), {name, "_fetch"});
      rel++;
    end
    stepCycle(1'b1, rbit(), 8'($urandom), pack(0, 0, 0, 0, 0, 1, 1), {name, "_done"});
    if (expDone != 0) checkValue({name, "_doneCycle"}, 32'(rel), 32'(expDone));
    stepCycle(1'b0, rbit(), 8'($urandom), pack(0, 0, 0, 0, 0, 0, 0), {name, "_idleAfter"});
    for (int k = 0; k < PAIRS; k++) begin
      checkValue({name, "_memB"}, {24'd0, memB[k]}, {24'd0, 8'(loaded[2*k] + loaded[2*k+1])});
    end
  endtask

  initial begin
    // Power-on reset: strobes and status low while reset is held.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      start = rbit();
      dataValid = rbit();
      #1;
      checkValue("resetHold", {27'd0, wea, ffEn, web, busy, done}, 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b0;
    dataValid = rbit();
    #1;
    checkValue("resetRelease", {22'd0, observed()}, 32'd0);

    runOnce(0, 17, "contig");
    runOnce(1, 25, "toggle");
    for (int r = 0; r < 3; r++) runOnce(2, 0, "random");

    // Reset held for two cycles in the middle of a FETCH1 cycle.
    stepCycle(1'b1, 1'b0, 8'h00, pack(0, 0, 0, 0, 0, 0, 0), "midRst_idleStart");
    for (int j = 0; j < DEPTH; j++) begin
      stepCycle(1'b0, 1'b1, 8'($urandom), pack(1, 3'(j), 0, 0, 0, 1, 0), "midRst_load");
    end
    for (int j = 0; j < 3; j++) begin
      stepCycle(1'b0, 1'b0, 8'h00,
                pack(0, 3'(j), (j % 2) == 0, (j % 2) == 1, 2'(j / 2), 1, 0), "midRst_fetch");
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checkValue("midRst_hold", {27'd0, wea, ffEn, web, busy, done}, 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkValue("midRst_release", {22'd0, observed()}, 32'd0);
    stepCycle(1'b0, 1'b1, 8'h00, pack(0, 0, 0, 0, 0, 0, 0), "midRst_idle");
    runOnce(0, 17, "afterRst");

`ifdef PAIR_SEQ_ABORT_EN
    stepCycle(1'b1, 1'b0, 8'h00, pack(0, 0, 0, 0, 0, 0, 0), "abort_idleStart");
    for (int j = 0; j < 3; j++) begin
      stepCycle(1'b0, 1'b1, 8'($urandom), pack(1, 3'(j), 0, 0, 0, 1, 0), "abort_load");
    end
    @(posedge clock);
    #1;
    abort = 1'b1;
    dataValid = 1'b1;
    #1;
    checkValue("abort_cycle", {22'd0, observed()}, {22'd0, pack(0, 3, 0, 0, 0, 1, 0)});
    @(posedge clock);
    #1;
    abort = 1'b0;
    #1;
    checkValue("abort_idle", {22'd0, observed()}, 32'd0);
    stepCycle(1'b0, 1'b0, 8'h00, pack(0, 0, 0, 0, 0, 0, 0), "abort_noDone");
    runOnce(0, 17, "afterAbort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
